// File: rtl/uart_frame_loader.sv
// UART (8N1) to framebuffer loader: a SYNC_BYTE starts a frame, then each byte becomes one 6-bit pixel.
// Optional trailing XOR checksum when UART_LOADER_CHECKSUM_EN is defined.
module uart_frame_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         IMG_W        = 128,
    parameter int         IMG_H        = 128,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [5:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [13:0]      LAST_ADDR = 14'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_CSUM} ld_state_t;
`else
    typedef enum logic [1:0] {L_IDLE, L_LOAD} ld_state_t;
`endif

    // Stage p0/p1: two-flop synchroniser; rx_prev feeds the falling-edge detector
    logic rx_p0, rx_p1, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            rx_prev <= rx_p1;
        end
    end

    rx_state_t        r_state, r_state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             byte_vld, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            r_state <= r_state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        byte_vld    = 1'b0;
        frame_err   = 1'b0;
        case (r_state)
            R_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_p1) r_state_nxt = R_START;
            end
            R_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    r_state_nxt = rx_p1 ? R_IDLE : R_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_p1, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) r_state_nxt = R_STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    if (rx_p1) begin
                        byte_vld    = 1'b1;
                        r_state_nxt = R_IDLE;
                    end else begin
                        frame_err   = 1'b1;
                        r_state_nxt = R_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            R_BREAK: begin
                // A held-low line must return high before another start bit is considered
                if (rx_p1) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    logic       ld_vld, ld_err;
    logic [7:0] ld_byte;

`ifdef UART_LOADER_CHECKSUM_EN
    // Stage p2: extra register between receiver and loader in checksum builds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_vld <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            ld_vld <= byte_vld;
            ld_err <= frame_err;
        end
    end

    always_ff @(posedge clk) begin
        ld_byte <= shift;
    end
`else
    assign ld_vld  = byte_vld;
    assign ld_err  = frame_err;
    assign ld_byte = shift;
`endif

    ld_state_t   l_state, l_state_nxt;
    logic [13:0] addr, addr_nxt;
    logic        wr_en_nxt, busy_nxt, frame_done_nxt, err_nxt;
    logic [13:0] wr_addr_nxt;
    logic [5:0]  wr_data_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  csum, csum_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state    <= L_IDLE;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            l_state    <= l_state_nxt;
            addr       <= addr_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            err        <= err_nxt;
`ifdef UART_LOADER_CHECKSUM_EN
            csum       <= csum_nxt;
`endif
        end
    end

    always_comb begin
        l_state_nxt    = l_state;
        addr_nxt       = addr;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        err_nxt        = err;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_nxt       = csum;
`endif
        case (l_state)
            L_IDLE: begin
                if (ld_vld && ld_byte == SYNC_BYTE) begin
                    l_state_nxt = L_LOAD;
                    busy_nxt    = 1'b1;
                    err_nxt     = 1'b0;
                    addr_nxt    = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_nxt    = '0;
`endif
                end
                if (ld_err) err_nxt = 1'b1;
            end
            L_LOAD: begin
                if (ld_vld) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr;
                    wr_data_nxt = ld_byte[5:0];
                    addr_nxt    = addr + 14'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_nxt    = csum ^ ld_byte;
`endif
                    if (addr == LAST_ADDR) begin
                        addr_nxt       = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        l_state_nxt    = L_CSUM;
`else
                        l_state_nxt    = L_IDLE;
                        busy_nxt       = 1'b0;
                        frame_done_nxt = 1'b1;
`endif
                    end
                end
                if (ld_err) begin
                    l_state_nxt = L_IDLE;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                    addr_nxt    = '0;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            L_CSUM: begin
                if (ld_vld) begin
                    l_state_nxt = L_IDLE;
                    busy_nxt    = 1'b0;
                    if (ld_byte == csum) frame_done_nxt = 1'b1;
                    else                 err_nxt        = 1'b1;
                end
                if (ld_err) begin
                    l_state_nxt = L_IDLE;
                    busy_nxt    = 1'b0;
                    err_nxt     = 1'b1;
                end
            end
`endif
            default: l_state_nxt = L_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader with CLKS_PER_BIT=8 and a 4x4 image.
// Also covers the trailer byte when UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_frame_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [5:0]  wr_data;
    logic        busy, frame_done, err;

    int checks = 0;
    int failures = 0;

    logic [13:0] log_addr[$];
    logic [5:0]  log_data[$];
    int          fd_cnt = 0;
    logic [13:0] fd_addr = '0;
    logic        fd_wr = 1'b0;
    logic [7:0]  frm [16];

    uart_frame_loader #(
        .CLKS_PER_BIT(CPB),
        .IMG_W(4),
        .IMG_H(4),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Write/frame_done logger sampled on the inactive edge
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_addr = wr_addr;
            fd_wr   = wr_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        fd_cnt = 0;
        fd_wr  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_body();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send_byte(frm[i], 1'b1);
            x = x ^ frm[i];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(x, 1'b1);
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, log_addr.size(), 16);
        for (int i = 0; i < 16 && i < log_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), log_data[i], frm[i][5:0]);
        end
        chk({tag, "_fd_cnt"}, fd_cnt, 1);
        chk({tag, "_fd_addr"}, fd_addr, 15);
`ifdef UART_LOADER_CHECKSUM_EN
        chk({tag, "_fd_with_wr"}, fd_wr, 0);
`else
        chk({tag, "_fd_with_wr"}, fd_wr, 1);
`endif
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Basic frame: A5, 00..0F
        for (int i = 0; i < 16; i++) frm[i] = 8'(i);
        clear_log();
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        chk("t1_busy_after_sync", busy, 1);
        send_body();
        check_writes("t1");
        chk("t1_hold_addr", wr_addr, 15);
        chk("t1_hold_data", wr_data, 6'h0F);

        // Junk before sync is dropped; FF becomes 3F
        frm[0] = 8'hFF;
        for (int i = 1; i < 16; i++) frm[i] = 8'(i * 37 + 5);
        clear_log();
        send_byte(8'h3C, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_busy_junk", busy, 0);
        send_byte(8'hA5, 1'b1);
        send_body();
        check_writes("t2");
        chk("t2_first_data", log_data.size() > 0 ? log_data[0] : 6'h00, 6'h3F);

        // Framing error mid-frame aborts; next A5 clears err and restarts at 0
        clear_log();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i), 1'b1);
        send_byte(8'h2A, 1'b0);
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_fd", fd_cnt, 0);
        chk("t3_nwr", log_addr.size(), 5);
        chk("t3_last_addr", wr_addr, 4);
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        chk("t3_err_cleared", err, 0);
        chk("t3_busy_again", busy, 1);
        clear_log();
        for (int i = 0; i < 16; i++) frm[i] = 8'(8'hC0 + i);
        send_body();
        check_writes("t3");

        // Reset mid-frame, then a fresh frame starts at addr 0
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h10 + i), 1'b1);
        chk("t4_busy_pre", busy, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_addr", wr_addr, 0);
        chk("t4_rst_data", wr_data, 0);
        chk("t4_rst_wr_en", wr_en, 0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        clear_log();
        for (int i = 0; i < 16; i++) frm[i] = 8'(i * 3);
        send_byte(8'hA5, 1'b1);
        send_body();
        check_writes("t4");

        // One-clock glitch is ignored; long break gives one framing error
        clear_log();
        rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("t5_glitch_nwr", log_addr.size(), 0);
        chk("t5_glitch_err", err, 0);
        rx = 1'b0;
        repeat (100 * CPB) @(negedge clk);
        chk("t5_break_err", err, 1);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk("t5_break_nwr", log_addr.size(), 0);
        chk("t5_break_busy", busy, 0);
        chk("t5_break_fd", fd_cnt, 0);
        for (int i = 0; i < 16; i++) frm[i] = 8'(8'h3F - i);
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5_recover_err", err, 0);
        send_body();
        check_writes("t5");

`ifdef UART_LOADER_CHECKSUM_EN
        // Bad trailer: pixels written, err set, no frame_done
        clear_log();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        chk("t6_busy_wait_csum", busy, 1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_nwr", log_addr.size(), 16);
        chk("t6_err", err, 1);
        chk("t6_fd", fd_cnt, 0);
        chk("t6_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
